// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared FSM state encoding and detector pattern constant.
//  Revision : 1.0
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/serial_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx_if
//  Purpose  : Control handshake and serial output bundle of the transmitter.
//  Revision : 1.0
// ============================================================================
interface serial_pattern_tx_if #(
    parameter int WIDTH  = 8,
    parameter int REPS_W = 4
);
    logic              start;
    logic [WIDTH-1:0]  pattern;
    logic [REPS_W-1:0] reps;
    logic              ready;
    logic              sout;
    logic              sout_valid;
    logic              frame_start;
    logic              done;

    modport master (
        output start, pattern, reps,
        input  ready, sout, sout_valid, frame_start, done
    );

    modport slave (
        input  start, pattern, reps,
        output ready, sout, sout_valid, frame_start, done
    );
endinterface : serial_pattern_tx_if
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift_reg
//  Purpose  : Parallel-load, MSB-first shift register; zeros shift in at LSB.
//  Revision : 1.0
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_shift,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_msb
);
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_data[WIDTH-1];
endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pattern_tx
//  Purpose  : Sends a captured pattern MSB-first, repeated with optional gaps.
//  Revision : 1.0
// ============================================================================
module serial_pattern_tx
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int REPS_W     = 4,
    parameter int GAP_CYCLES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    serial_pattern_tx_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] c_IDX_MAX = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] c_GAP_MAX = GAP_W'(GAP_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [REPS_W-1:0] r_reps_left, w_reps_nxt;
    logic [GAP_W-1:0]  r_gap, w_gap_nxt;
    logic [WIDTH-1:0]  r_pattern, w_pattern_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_fs, w_fs_nxt;
    logic              r_done, w_done_nxt;
    logic              w_load, w_shift;
    logic [WIDTH-1:0]  w_load_data;
    logic              w_msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_reps_left <= '0;
            r_gap       <= '0;
            r_pattern   <= '0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_fs        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_reps_left <= w_reps_nxt;
            r_gap       <= w_gap_nxt;
            r_pattern   <= w_pattern_nxt;
            r_ready     <= w_ready_nxt;
            r_valid     <= w_valid_nxt;
            r_fs        <= w_fs_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Every transition that puts an MSB on the line reloads the shifter
    // and asserts valid/frame_start in the same edge, so there is no bubble.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_reps_nxt    = r_reps_left;
        w_gap_nxt     = r_gap;
        w_pattern_nxt = r_pattern;
        w_ready_nxt   = 1'b0;
        w_valid_nxt   = 1'b0;
        w_fs_nxt      = 1'b0;
        w_done_nxt    = 1'b0;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_load_data   = r_pattern;

        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                if (bus.start) begin
                    w_state_nxt   = SHIFT;
                    w_pattern_nxt = bus.pattern;
                    w_load_data   = bus.pattern;
                    w_reps_nxt    = (bus.reps == '0) ? '0 : bus.reps - 1'b1;
                    w_idx_nxt     = c_IDX_MAX;
                    w_load        = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_fs_nxt      = 1'b1;
                    w_ready_nxt   = 1'b0;
                end
            end
            SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_nxt   = r_idx - 1'b1;
                    w_shift     = 1'b1;
                    w_valid_nxt = 1'b1;
                end else if (r_reps_left == '0) begin
                    w_state_nxt = DONE;
                    w_shift     = 1'b1;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_reps_nxt = r_reps_left - 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt = GAP;
                        w_gap_nxt   = c_GAP_MAX;
                        w_shift     = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_idx_nxt   = c_IDX_MAX;
                        w_valid_nxt = 1'b1;
                        w_fs_nxt    = 1'b1;
                    end
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                    w_idx_nxt   = c_IDX_MAX;
                    w_valid_nxt = 1'b1;
                    w_fs_nxt    = 1'b1;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The shifter empties to zero after the last bit, so sout idles low.
    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_data),
        .o_msb   (w_msb)
    );

    assign bus.ready       = r_ready;
    assign bus.sout        = w_msb;
    assign bus.sout_valid  = r_valid;
    assign bus.frame_start = r_fs;
    assign bus.done        = r_done;
endmodule : serial_pattern_tx
`default_nettype wire
